// File: rtl/sme_pkg.sv
// -----------------------------------------------------------------------------
// sme_pkg
//   Shared definitions for the string-matching-engine job scheduler:
//   FSM state encoding, default job length limits, job-kind constants and
//   a saturating length-counter helper.
// -----------------------------------------------------------------------------
package sme_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // Default job length limits in characters
  localparam int MAX_STR_DEF = 32;
  localparam int MAX_PAT_DEF = 8;

  // Job buffer holds one whole job; sized for the longest legal job
  localparam int BUF_DEPTH = 32;

  // Job kind as carried on c_kind / rsp_kind
  localparam logic KIND_STR = 1'b0;
  localparam logic KIND_PAT = 1'b1;

  // Length counters are wide enough to see an over-long job without wrapping
  localparam int LEN_W = 6;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + LEN_W'(1);
  endfunction

endpackage

// File: rtl/sme_job_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter. The combinational pick starts searching at the
//   client after the last released one, so a client that just finished a
//   session has lowest priority next time. The pointer only moves when the
//   owner of a grant releases it.
//
//   clk, reset : clock, synchronous active-high reset
//   req        : per-client request vector
//   rel        : pulse, the current grant is being released
//   rel_idx    : index of the client releasing its grant
//   gnt        : one-hot pick among the requesters (combinational)
//   idx        : binary index of the pick
//   any        : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          rel,
  input  logic [IW-1:0] rel_idx,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] last;

  function automatic logic [IW-1:0] mod_n(input int v);
    return IW'(v % N);
  endfunction

  // Reset value makes client 0 the first in line.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= IW'(N - 1);
    end else if (rel) begin
      last <= rel_idx;
    end
  end

  // NOTE: every output of a combinational block is given a default before
  // any conditional assignment so no path leaves it unassigned (no latch).
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[mod_n(int'(last) + k)]) begin
        any      = 1'b1;
        idx      = mod_n(int'(last) + k);
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sme_job_sched.sv
// -----------------------------------------------------------------------------
// sme_job_sched
//   Session scheduler and job sequencer in front of the shared string-matching
//   engine. Clients open a session, stream a job one character at a time
//   (string load or pattern query), the job is buffered whole and then burst
//   into the engine with no gaps. Pattern jobs wait for the engine result
//   (or a timeout) and every job produces exactly one response.
//
//   clk, reset        : clock, synchronous active-high reset (shared with SME)
//   sess_req/sess_gnt : per-client session request / one-hot grant
//   c_valid/c_data/c_kind/c_last/c_ready : per-client character stream
//   sme_chardata, sme_isstring, sme_ispattern : registered engine drive
//   sme_valid, sme_match, sme_match_index     : engine result
//   rsp_valid/rsp_ready, rsp_client, rsp_kind, rsp_match, rsp_index, rsp_err :
//                       response port, fields held while not accepted
// -----------------------------------------------------------------------------
module sme_job_sched
  import sme_pkg::*;
#(
  parameter int N_CLIENT = 2,
  parameter int MAX_STR  = MAX_STR_DEF,
  parameter int MAX_PAT  = MAX_PAT_DEF,
  parameter int TIMEOUT  = 1023
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CLIENT-1:0]         sess_req,
  output logic [N_CLIENT-1:0]         sess_gnt,
  input  logic [N_CLIENT-1:0]         c_valid,
  input  logic [N_CLIENT-1:0][7:0]    c_data,
  input  logic [N_CLIENT-1:0]         c_kind,
  input  logic [N_CLIENT-1:0]         c_last,
  output logic [N_CLIENT-1:0]         c_ready,
  output logic [7:0]                  sme_chardata,
  output logic                        sme_isstring,
  output logic                        sme_ispattern,
  input  logic                        sme_valid,
  input  logic                        sme_match,
  input  logic [4:0]                  sme_match_index,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(N_CLIENT)-1:0] rsp_client,
  output logic                        rsp_kind,
  output logic                        rsp_match,
  output logic [4:0]                  rsp_index,
  output logic                        rsp_err
);

  localparam int CW = $clog2(N_CLIENT);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BUF_DEPTH);

  state_t state, state_nxt;

  logic [N_CLIENT-1:0] gnt;
  logic [CW-1:0]       gidx;
  logic [7:0]          job_buf [BUF_DEPTH];
  logic [LEN_W-1:0]    len;      // characters received for the current job
  logic [LEN_W-1:0]    rd;       // characters already sent to the engine
  logic                kind;
  logic                loaded;   // a string was loaded in this session
  logic [TW-1:0]       cnt;

  logic [N_CLIENT-1:0] arb_gnt;
  logic [CW-1:0]       arb_idx;
  logic                arb_any;

  logic                beat, last_beat, job_kind, job_err, rel;
  logic [LEN_W-1:0]    len_inc, lim;
  logic                fill_match, fill_err;
  logic [4:0]          fill_index;

  rr_arbiter #(.N(N_CLIENT)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (sess_req),
    .rel     (rel),
    .rel_idx (gidx),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  assign sess_gnt = gnt;
  assign c_ready  = (state == S_LOAD) ? gnt : '0;

  // Job decode. The kind is only valid on the first beat, so it is taken
  // straight from the port while nothing has been counted yet.
  always_comb begin
    beat      = (state == S_LOAD) && c_valid[gidx];
    last_beat = beat && c_last[gidx];
    job_kind  = (len == '0) ? c_kind[gidx] : kind;
    lim       = (job_kind == KIND_PAT) ? LEN_W'(MAX_PAT) : LEN_W'(MAX_STR);
    len_inc   = sat_inc(len);
    job_err   = (len_inc > lim) || ((job_kind == KIND_PAT) && !loaded);
  end

  // FSM next state, grant release and the response payload to capture on
  // entry to S_RESP.
  always_comb begin
    state_nxt  = state;
    rel        = 1'b0;
    fill_match = 1'b0;
    fill_index = '0;
    fill_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_any) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        fill_err = 1'b1;
        if (last_beat) begin
          state_nxt = job_err ? S_RESP : S_ISSUE;
        end else if (!beat && (len == '0) && !sess_req[gidx]) begin
          state_nxt = S_IDLE;
          rel       = 1'b1;
        end
      end
      S_ISSUE: begin
        if (rd == len) state_nxt = (kind == KIND_STR) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (sme_valid) begin
          state_nxt  = S_RESP;
          fill_match = sme_match;
          fill_index = sme_match_index;
        end else if (cnt == TW'(TIMEOUT - 1)) begin
          state_nxt = S_RESP;
          fill_err  = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (sess_req[gidx]) begin
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_IDLE;
            rel       = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so every register in
  // the design samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt           <= '0;
      gidx          <= '0;
      len           <= '0;
      rd            <= '0;
      kind          <= KIND_STR;
      loaded        <= 1'b0;
      cnt           <= '0;
      sme_chardata  <= '0;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_client    <= '0;
      rsp_kind      <= 1'b0;
      rsp_match     <= 1'b0;
      rsp_index     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            gnt  <= arb_gnt;
            gidx <= arb_idx;
            len  <= '0;
          end
        end
        S_LOAD: begin
          if (beat) begin
            len  <= len_inc;
            kind <= job_kind;
          end
          // The first character goes out on the edge that accepts the last
          // beat; for a one-character job it is still on the port.
          if (last_beat && !job_err) begin
            sme_chardata  <= (len == '0) ? c_data[gidx] : job_buf[0];
            sme_isstring  <= (job_kind == KIND_STR);
            sme_ispattern <= (job_kind == KIND_PAT);
            rd            <= LEN_W'(1);
          end
        end
        S_ISSUE: begin
          if (rd == len) begin
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            cnt           <= '0;
            if (kind == KIND_STR) loaded <= 1'b1;
          end else begin
            sme_chardata <= job_buf[rd[BW-1:0]];
            rd           <= rd + LEN_W'(1);
          end
        end
        S_WAIT: begin
          cnt <= cnt + TW'(1);
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            len       <= '0;
          end
        end
        default: ;
      endcase

      // Response fields are written only on entry to S_RESP, so they stay
      // stable for as long as the response is stalled.
      if ((state_nxt == S_RESP) && (state != S_RESP)) begin
        rsp_valid  <= 1'b1;
        rsp_client <= gidx;
        rsp_kind   <= job_kind;
        rsp_match  <= fill_match;
        rsp_index  <= fill_index;
        rsp_err    <= fill_err;
      end

      // Ending a session forgets its string.
      if (rel) begin
        gnt    <= '0;
        loaded <= 1'b0;
      end
    end
  end

  // NOTE: the job buffer has no reset; every byte is written before it is
  // read within a job, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (beat && (len < lim) && !len[LEN_W-1]) begin
      job_buf[len[BW-1:0]] <= c_data[gidx];
    end
  end

endmodule

// File: tb/tb_sme_job_sched.sv
// -----------------------------------------------------------------------------
// tb_sme_job_sched
//   Directed self-checking bench for sme_job_sched with a hand-driven model of
//   the string-matching engine. Inputs change 1 ns after the rising edge and
//   outputs are read at that point or on the falling edge.
// -----------------------------------------------------------------------------
module tb_sme_job_sched;
  import sme_pkg::*;

  localparam int N_CLIENT = 2;
  localparam int TIMEOUT  = 1023;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       sess_req, sess_gnt;
  logic [1:0]       c_valid, c_kind, c_last, c_ready;
  logic [1:0][7:0]  c_data;
  logic [7:0]       sme_chardata;
  logic             sme_isstring, sme_ispattern;
  logic             sme_valid, sme_match;
  logic [4:0]       sme_match_index;
  logic             rsp_valid, rsp_ready;
  logic [0:0]       rsp_client;
  logic             rsp_kind, rsp_match, rsp_err;
  logic [4:0]       rsp_index;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Engine-side monitor state
  logic [7:0] sme_chars[$];
  int str_cycles  = 0;
  int pat_cycles  = 0;
  int run_len     = 0;
  int run_start   = 0;
  int last_strobe = 0;

  sme_job_sched #(
    .N_CLIENT (N_CLIENT),
    .MAX_STR  (32),
    .MAX_PAT  (8),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sess_req        (sess_req),
    .sess_gnt        (sess_gnt),
    .c_valid         (c_valid),
    .c_data          (c_data),
    .c_kind          (c_kind),
    .c_last          (c_last),
    .c_ready         (c_ready),
    .sme_chardata    (sme_chardata),
    .sme_isstring    (sme_isstring),
    .sme_ispattern   (sme_ispattern),
    .sme_valid       (sme_valid),
    .sme_match       (sme_match),
    .sme_match_index (sme_match_index),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_client      (rsp_client),
    .rsp_kind        (rsp_kind),
    .rsp_match       (rsp_match),
    .rsp_index       (rsp_index),
    .rsp_err         (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sme_isstring || sme_ispattern) begin
      if (run_len == 0) run_start = cyc;
      run_len++;
      last_strobe = cyc;
      sme_chars.push_back(sme_chardata);
      if (sme_isstring)  str_cycles++;
      if (sme_ispattern) pat_cycles++;
    end else begin
      run_len = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack_str(input string s);
    logic [63:0] v = '0;
    logic [7:0]  b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      v = (v << 8) | {56'd0, b};
    end
    return v;
  endfunction

  function automatic logic [63:0] pack_q();
    logic [63:0] v = '0;
    foreach (sme_chars[i]) v = (v << 8) | {56'd0, sme_chars[i]};
    return v;
  endfunction

  // Streams one job on client c; returns one cycle after the last beat is
  // accepted. gap idle cycles are inserted between beats.
  task automatic send_job(input int c, input logic kind, input string s,
                          input int gap, input string tag);
    int accepted = 0;
    for (int i = 0; i < s.len(); i++) begin
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      c_valid[c] = 1'b1;
      c_data[c]  = s[i];
      c_kind[c]  = kind;
      c_last[c]  = (i == s.len() - 1);
      while (!acc && n < 50) begin
        acc = c_ready[c];
        tick();
        n++;
      end
      c_valid[c] = 1'b0;
      c_last[c]  = 1'b0;
      if (!acc) break;
      accepted++;
      if (i != s.len() - 1) repeat (gap) tick();
    end
    check({tag, "_beats"}, accepted, s.len());
  endtask

  task automatic wait_rsp(input string tag, output int at);
    int n = 0;
    while (!rsp_valid && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, rsp_valid, 1);
    at = cyc;
  endtask

  task automatic wait_strobe_low(input string tag);
    int n = 0;
    while ((sme_isstring || sme_ispattern) && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_strobe_low"}, {sme_isstring, sme_ispattern}, 0);
  endtask

  task automatic wait_gnt(input string tag, input logic [1:0] exp);
    int n = 0;
    while (sess_gnt !== exp && n < 20) begin
      tick();
      n++;
    end
    check(tag, sess_gnt, exp);
  endtask

  task automatic check_rsp(input string tag, input logic [0:0] client, input logic kind,
                           input logic match, input logic [4:0] index, input logic err);
    check(tag, {rsp_valid, rsp_client, rsp_kind, rsp_match, rsp_index, rsp_err},
               {1'b1, client, kind, match, index, err});
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic sme_reply(input logic match, input logic [4:0] index);
    sme_valid       = 1'b1;
    sme_match       = match;
    sme_match_index = index;
    tick();
    sme_valid       = 1'b0;
    sme_match       = 1'b0;
    sme_match_index = '0;
  endtask

  initial begin
    int t, s0, p0;
    reset           = 1'b1;
    sess_req        = '0;
    c_valid         = '0;
    c_data          = '0;
    c_kind          = '0;
    c_last          = '0;
    sme_valid       = 1'b0;
    sme_match       = 1'b0;
    sme_match_index = '0;
    rsp_ready       = 1'b0;
    repeat (3) tick();

    check("rst_gnt_ready", {sess_gnt, c_ready}, 0);
    check("rst_sme", {sme_isstring, sme_ispattern, sme_chardata}, 0);
    check("rst_rsp", {rsp_valid, rsp_client, rsp_kind, rsp_match, rsp_index, rsp_err}, 0);
    reset = 1'b0;
    tick();

    // Both clients request together: client 0 wins, grant one cycle later
    sess_req = 2'b11;
    tick();
    check("gnt_first", sess_gnt, 2'b01);
    check("ready_first", c_ready, 2'b01);

    // String "abcde"
    sme_chars.delete();
    s0 = str_cycles;
    send_job(0, KIND_STR, "abcde", 0, "str1");
    wait_rsp("str1", t);
    check_rsp("str1_rsp", 1'b0, KIND_STR, 1'b0, 5'd0, 1'b0);
    check("str1_lat", t - last_strobe, 1);
    check("str1_cycles", str_cycles - s0, 5);
    check("str1_contig", last_strobe - run_start + 1, 5);
    check("str1_chars", pack_q(), pack_str("abcde"));
    handshake();

    // Pattern "cd", engine answers match at index 2
    sme_chars.delete();
    p0 = pat_cycles;
    send_job(0, KIND_PAT, "cd", 0, "pat1");
    wait_strobe_low("pat1");
    sme_reply(1'b1, 5'd2);
    check_rsp("pat1_rsp", 1'b0, KIND_PAT, 1'b1, 5'd2, 1'b0);
    check("pat1_chars", pack_q(), pack_str("cd"));
    check("pat1_cycles", pat_cycles - p0, 2);
    handshake();

    // Engine valid outside WAIT produces nothing
    sme_reply(1'b1, 5'd9);
    tick();
    check("stray_valid", rsp_valid, 0);

    // String with 3-cycle gaps between beats reaches the engine gap-free
    sme_chars.delete();
    s0 = str_cycles;
    send_job(0, KIND_STR, "hello", 3, "gap");
    wait_rsp("gap", t);
    check_rsp("gap_rsp", 1'b0, KIND_STR, 1'b0, 5'd0, 1'b0);
    check("gap_cycles", str_cycles - s0, 5);
    check("gap_contig", last_strobe - run_start + 1, 5);
    check("gap_chars", pack_q(), pack_str("hello"));
    handshake();

    // Client 0 ends its session, client 1 takes over
    sess_req[0] = 1'b0;
    wait_gnt("gnt_c1", 2'b10);

    // Pattern in a fresh session without a string
    s0 = str_cycles;
    p0 = pat_cycles;
    send_job(1, KIND_PAT, "ab", 0, "nostr");
    wait_rsp("nostr", t);
    check_rsp("nostr_rsp", 1'b1, KIND_PAT, 1'b0, 5'd0, 1'b1);
    handshake();
    check("nostr_sme", (str_cycles - s0) + (pat_cycles - p0), 0);

    // Client 0 asks again but client 1 keeps its session
    sess_req[0] = 1'b1;
    repeat (3) tick();
    check("gnt_hold", sess_gnt, 2'b10);

    sme_chars.delete();
    send_job(1, KIND_STR, "xyz", 0, "str2");
    wait_rsp("str2", t);
    check_rsp("str2_rsp", 1'b1, KIND_STR, 1'b0, 5'd0, 1'b0);
    check("str2_chars", pack_q(), pack_str("xyz"));
    handshake();

    // 9-character pattern: all beats taken, engine untouched, error
    p0 = pat_cycles;
    send_job(1, KIND_PAT, "abcdefghi", 0, "long");
    wait_rsp("long", t);
    check_rsp("long_rsp", 1'b1, KIND_PAT, 1'b0, 5'd0, 1'b1);
    handshake();
    check("long_sme", pat_cycles - p0, 0);

    // Engine never answers: timeout, then a 4-cycle stalled response
    send_job(1, KIND_PAT, "xy", 0, "tmo");
    wait_rsp("tmo", t);
    check("tmo_lat", t - last_strobe, TIMEOUT + 1);
    for (int i = 0; i < 4; i++) begin
      check_rsp("tmo_hold", 1'b1, KIND_PAT, 1'b0, 5'd0, 1'b1);
      tick();
    end
    sess_req[1] = 1'b0;
    handshake();
    wait_gnt("gnt_back_c0", 2'b01);

    // Reset in the middle of an engine burst
    send_job(0, KIND_STR, "abcdefgh", 0, "rstmid");
    tick();
    check("rstmid_in_issue", sme_isstring, 1);
    reset = 1'b1;
    tick();
    check("rstmid_gnt_ready", {sess_gnt, c_ready}, 0);
    check("rstmid_sme", {sme_isstring, sme_ispattern, sme_chardata}, 0);
    check("rstmid_rsp", {rsp_valid, rsp_client, rsp_kind, rsp_match, rsp_index, rsp_err}, 0);
    reset = 1'b0;
    wait_gnt("gnt_after_rst", 2'b01);

    // Fresh session: one-character string, then one-character pattern
    sme_chars.delete();
    s0 = str_cycles;
    send_job(0, KIND_STR, "q", 0, "str3");
    wait_rsp("str3", t);
    check_rsp("str3_rsp", 1'b0, KIND_STR, 1'b0, 5'd0, 1'b0);
    check("str3_lat", t - last_strobe, 1);
    check("str3_cycles", str_cycles - s0, 1);
    handshake();

    sme_chars.delete();
    send_job(0, KIND_PAT, "q", 0, "pat3");
    wait_strobe_low("pat3");
    sme_reply(1'b1, 5'd17);
    check_rsp("pat3_rsp", 1'b0, KIND_PAT, 1'b1, 5'd17, 1'b0);
    check("pat3_chars", pack_q(), pack_str("q"));
    sess_req = '0;
    handshake();
    repeat (2) tick();
    check("end_idle", {sess_gnt, rsp_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sme_job_sched.md
# sme_job_sched

Scheduler and sequencer in front of the shared string-matching engine (SME). Up to `N_CLIENT` clients each open a session and send jobs, one character at a time: a string load, or a pattern query. The block round-robin arbitrates sessions, buffers each job whole, and bursts it into the SME gap-free. It then waits for the SME result and returns it to the owning client through a single response port.

## Interface
- `N_CLIENT`, 2, number of requesting clients (≥2)
- `MAX_STR`, 32, max string length in characters
- `MAX_PAT`, 8, max pattern length in characters
- `TIMEOUT`, 1023, cycles to wait for SME `valid` before aborting a pattern job
- `clk` in 1: the single clock
- `reset` in 1: synchronous, active-high
- `sess_req` in N_CLIENT: client i requests/holds a session
- `sess_gnt` out N_CLIENT: one-hot session grant
- `c_valid` in N_CLIENT: character valid, per client
- `c_data` in N_CLIENT×8: character, per client
- `c_kind` in N_CLIENT: 0 = string job, 1 = pattern job; sampled on the first character of the job
- `c_last` in N_CLIENT: final character of the job
- `c_ready` out N_CLIENT: character accepted
- `sme_chardata` out 8: to SME `chardata`
- `sme_isstring`, `sme_ispattern` out 1 each: to SME
- `sme_valid`, `sme_match` in 1 each: from SME
- `sme_match_index` in 5: from SME
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake
- `rsp_client` out $clog2(N_CLIENT): owning client
- `rsp_kind`, `rsp_match` out 1 each
- `rsp_index` out 5
- `rsp_err` out 1

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, RESP.
- **IDLE**: no grant.
  - Any `sess_req` high → grant via round-robin, starting after the last granted client. After reset, client 0 has highest priority. → LOAD.
- **LOAD**: `c_ready[g]` is high; each `c_valid[g]` beat is written to a 32-byte job buffer.
  - Gaps between beats are allowed.
  - Beat with `c_last` → ISSUE.
  - If the count exceeds the limit (`MAX_STR` or `MAX_PAT`), further characters are accepted and discarded. The job is flagged error and skips ISSUE/WAIT → RESP.
  - A pattern job with no string loaded in the current session is also error → RESP, SME untouched.
  - If `sess_req[g]` is low and no job is started → release grant → IDLE.
- **ISSUE**: one buffered character per cycle on `sme_chardata`, with `sme_isstring` (string job) or `sme_ispattern` (pattern job) high for exactly L consecutive cycles.
  - String job → RESP with `rsp_match`=0, `rsp_index`=0, `rsp_err`=0; marks the session's string as loaded.
  - Pattern job → WAIT.
- **WAIT**: both SME strobes are low; a cycle counter runs.
  - `sme_valid` high → capture `sme_match` and `sme_match_index` → RESP.
  - Counter reaches `TIMEOUT` → `rsp_err`=1, `rsp_match`=0 → RESP.
  - `sme_valid` outside WAIT is ignored.
- **RESP**: `rsp_*` fields are held stable while `rsp_valid`=1 && !`rsp_ready`.
  - On handshake: if `sess_req[g]` is still high → LOAD with the same grant; else release grant and clear the loaded flag → IDLE.
- A session drop mid-job does not abort the job; release happens only after its response.

## Timing
- Reset values:
  - `sess_gnt`, `c_ready`, `sme_isstring`, `sme_ispattern`, `rsp_valid`, `rsp_match`, `rsp_err`, `rsp_kind` = 0
  - `sme_chardata`, `rsp_index`, `rsp_client` = 0
  - Round-robin pointer = last granted is N_CLIENT-1
  - Loaded flag clear
- Reset mid-operation returns to IDLE the next cycle, with no response. The SME shares this reset.
- Grant appears 1 cycle after `sess_req` is sampled high in IDLE. `c_ready` goes high in the same cycle as `sess_gnt`.
- First SME character appears the cycle after the `c_last` beat is accepted. All SME outputs are registered.
- String response: `rsp_valid` rises the cycle after the final SME character.
- Pattern response: `rsp_valid` rises the cycle after `sme_valid` is sampled.
- Length counters are 6 bits and saturate; no wrap.

## Structure
- Package `sme_pkg` holds:
  - state enum
  - `MAX_STR`/`MAX_PAT` defaults
  - kind constants `KIND_STR`=0, `KIND_PAT`=1
- Sub-module `rr_arbiter` (N requests, one-hot grant, update on release).
- Job buffer and FSM live in the top module.

## Test plan
- Single client: string "abcde", then pattern "cd" with SME model returning match=1, index=2 → string ack (0,0,err 0), then rsp(client 0, match 1, index 2). `sme_isstring` high exactly 5 consecutive cycles.
- Client 0 sends a string with 3-cycle gaps between beats → SME sees 5 contiguous characters, no gap.
- Both clients raise `sess_req` in the same cycle after reset → client 0 granted. After client 0 drops its session, client 1 is granted. The next simultaneous request goes to client 0 only after client 1 releases.
- Pattern of 9 characters → all 9 accepted, SME strobes never asserted, rsp_err=1. A pattern sent in a new session before any string → rsp_err=1.
- SME model never raises `valid` → rsp_err=1 exactly `TIMEOUT`+1 cycles after the last pattern character. `rsp_ready` held low 4 cycles → response fields stable throughout.
- Reset asserted during ISSUE → next cycle all outputs are at their reset values. A fresh session then completes normally.
